banner_frame_ctrl: RTL and testbench

- Frame-level controller sitting between the UART receiver byte stream and the serial2parallel symbol assembler.
- Hunts for a start-of-frame byte and arms the assembler.
- Forwards exactly N payload symbols, then waits for the assembler's done pulse and commits the assembled word to the banner register.
- Recovers the assembler from stalled or aborted frames by flushing it with dummy symbols.

---
 rtl/banner_frame_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_banner_frame_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/banner_frame_ctrl.sv
// Frame controller between the UART byte stream and the serial2parallel assembler.
// Optional trailing XOR checksum byte: define BANNER_CHECKSUM_EN.
module banner_frame_ctrl #(
  parameter int         W           = 4,
  parameter int         N           = 6,
  parameter logic [7:0] SOF         = 8'h02,
  parameter int         TIMEOUT_CYC = 1000
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [7:0]     rx_data,
  input  logic           rx_valid,
  output logic           s2p_start,
  output logic [W-1:0]   s2p_data,
  output logic           s2p_new_data,
  input  logic           s2p_done,
  input  logic [W*N-1:0] s2p_word,
  output logic [W*N-1:0] banner_out,
  output logic           banner_update,
  output logic           frame_err,
  output logic           busy
);

  localparam int TMAX = (TIMEOUT_CYC > 3) ? TIMEOUT_CYC : 3;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int SW   = $clog2(N + 1);

  localparam logic [TW-1:0] TO    = TW'(TIMEOUT_CYC);
  localparam logic [TW-1:0] GUARD = TW'(3);
  localparam logic [SW-1:0] LAST  = SW'(N - 1);

  typedef enum logic [2:0] {
    IDLE, ARM, PAYLOAD, WAIT_DONE, COMMIT, FLUSH, FLUSH_WAIT
`ifdef BANNER_CHECKSUM_EN
    , CHECK
`endif
  } state_t;

  state_t         state, state_d;
  logic [SW-1:0]  sent, sent_d;
  logic [TW-1:0]  tmr, tmr_d;
  logic [W*N-1:0] word_q, word_d;
  logic           start_d, new_d, upd_d, err_d;
  logic [W-1:0]   data_d;
  logic [W*N-1:0] banner_d;
`ifdef BANNER_CHECKSUM_EN
  logic [7:0]     csum, csum_d;
  logic           seen, seen_d;
`endif

  always_comb begin
    state_d  = state;
    sent_d   = sent;
    tmr_d    = tmr;
    word_d   = word_q;
    start_d  = 1'b0;
    new_d    = 1'b0;
    data_d   = s2p_data;
    banner_d = banner_out;
    upd_d    = 1'b0;
    err_d    = 1'b0;
`ifdef BANNER_CHECKSUM_EN
    csum_d   = csum;
    seen_d   = seen;
`endif
    unique case (state)
      IDLE: begin
        if (rx_valid && rx_data == SOF) begin
          state_d = ARM;
          start_d = 1'b1;
          sent_d  = '0;
          tmr_d   = '0;
`ifdef BANNER_CHECKSUM_EN
          csum_d  = '0;
          seen_d  = 1'b0;
`endif
        end
      end
      ARM, PAYLOAD: begin
        state_d = PAYLOAD;
        if (rx_valid) begin
          data_d = rx_data[W-1:0];
          new_d  = 1'b1;
          sent_d = sent + SW'(1);
          tmr_d  = '0;
`ifdef BANNER_CHECKSUM_EN
          csum_d = csum ^ rx_data;
          if (sent == LAST) state_d = CHECK;
`else
          if (sent == LAST) state_d = WAIT_DONE;
`endif
        end else if (state == PAYLOAD) begin
          if (tmr == TO) begin
            err_d   = 1'b1;
            state_d = FLUSH;
          end else begin
            tmr_d = tmr + TW'(1);
          end
        end
      end
`ifdef BANNER_CHECKSUM_EN
      CHECK: begin
        if (s2p_done) begin
          word_d = s2p_word;
          seen_d = 1'b1;
        end
        if (rx_valid) begin
          tmr_d = '0;
          if (rx_data == csum) begin
            state_d = (seen || s2p_done) ? COMMIT : WAIT_DONE;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end else if (tmr == TO) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          tmr_d = tmr + TW'(1);
        end
      end
`endif
      WAIT_DONE: begin
        if (s2p_done) begin
          word_d  = s2p_word;
          state_d = COMMIT;
        end else if (tmr == GUARD) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          tmr_d = tmr + TW'(1);
        end
      end
      COMMIT: begin
        banner_d = word_q;
        upd_d    = 1'b1;
        state_d  = IDLE;
      end
      FLUSH: begin
        // pad the assembler with zero symbols so it completes and re-idles
        new_d  = 1'b1;
        data_d = '0;
        sent_d = sent + SW'(1);
        if (sent == LAST) begin
          state_d = FLUSH_WAIT;
          tmr_d   = '0;
        end
      end
      FLUSH_WAIT: begin
        if (s2p_done) begin
          state_d = IDLE;
        end else if (tmr == GUARD) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          tmr_d = tmr + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      sent          <= '0;
      tmr           <= '0;
      word_q        <= '0;
      s2p_start     <= 1'b0;
      s2p_data      <= '0;
      s2p_new_data  <= 1'b0;
      banner_out    <= '0;
      banner_update <= 1'b0;
      frame_err     <= 1'b0;
      busy          <= 1'b0;
`ifdef BANNER_CHECKSUM_EN
      csum          <= '0;
      seen          <= 1'b0;
`endif
    end else begin
      state         <= state_d;
      sent          <= sent_d;
      tmr           <= tmr_d;
      word_q        <= word_d;
      s2p_start     <= start_d;
      s2p_data      <= data_d;
      s2p_new_data  <= new_d;
      banner_out    <= banner_d;
      banner_update <= upd_d;
      frame_err     <= err_d;
      busy          <= (state_d != IDLE);
`ifdef BANNER_CHECKSUM_EN
      csum          <= csum_d;
      seen          <= seen_d;
`endif
    end
  end

endmodule

// File: tb/tb_banner_frame_ctrl.sv
// Randomized bench for banner_frame_ctrl with a behavioural assembler
// and frame-level expectations.
module tb_banner_frame_ctrl;

  localparam int         W   = 4;
  localparam int         NS  = 6;
  localparam logic [7:0] SOF = 8'h02;
  localparam int         TO  = 1000;
  localparam int         BW  = W * NS;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [7:0]    rx_data = '0;
  logic          rx_valid = 1'b0;
  logic          s2p_start;
  logic [W-1:0]  s2p_data;
  logic          s2p_new_data;
  logic          s2p_done;
  logic [BW-1:0] s2p_word;
  logic [BW-1:0] banner_out;
  logic          banner_update;
  logic          frame_err;
  logic          busy;

  banner_frame_ctrl #(.W(W), .N(NS), .SOF(SOF), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .s2p_start(s2p_start), .s2p_data(s2p_data),
    .s2p_new_data(s2p_new_data), .s2p_done(s2p_done),
    .s2p_word(s2p_word), .banner_out(banner_out),
    .banner_update(banner_update), .frame_err(frame_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // behavioural serial2parallel assembler, first symbol lands in the MSBs
  logic [BW-1:0] a_sr;
  int            a_cnt;
  logic          a_on;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_sr <= '0; a_cnt <= 0; a_on <= 1'b0;
      s2p_done <= 1'b0; s2p_word <= '0;
    end else begin
      s2p_done <= 1'b0;
      if (s2p_start) begin
        a_on <= 1'b1; a_cnt <= 0; a_sr <= '0;
      end else if (a_on && s2p_new_data) begin
        a_sr  <= (a_sr << W) | BW'(s2p_data);
        a_cnt <= a_cnt + 1;
        if (a_cnt == NS - 1) begin
          s2p_done <= 1'b1;
          s2p_word <= (a_sr << W) | BW'(s2p_data);
          a_on     <= 1'b0;
        end
      end
    end
  end

  logic [W-1:0] sq[$];
  int n_start, n_upd, n_ferr, n_overlap;
  always @(negedge clk) begin
    if (reset_n) begin
      if (s2p_new_data) sq.push_back(s2p_data);
      if (s2p_start) n_start++;
      if (banner_update) n_upd++;
      if (frame_err) n_ferr++;
      if (s2p_start && s2p_new_data) n_overlap++;
    end
  end

  int n_chk = 0;
  int n_bad = 0;
  logic [BW-1:0] banner_exp = '0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic mon_clear();
    sq.delete();
    n_start = 0; n_upd = 0; n_ferr = 0;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rx_data  = $urandom;
    repeat (gap) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int limit, output int waited);
    waited = 0;
    while (busy && waited < limit) begin
      @(negedge clk);
      waited++;
    end
    if (busy) chk("idle_timeout", 1, 0);
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
  endtask

  function automatic logic [BW-1:0] pack(input logic [7:0] p[NS]);
    logic [BW-1:0] acc = '0;
    for (int i = 0; i < NS; i++)
      acc = (acc << W) | BW'(p[i] % (1 << W));
    return acc;
  endfunction

  task automatic check_syms(input string tag, input logic [W-1:0] e[$]);
    chk({tag, "_nsym"}, sq.size(), e.size());
    for (int i = 0; i < e.size() && i < sq.size(); i++)
      chk($sformatf("%s_sym%0d", tag, i), sq[i], e[i]);
  endtask

  // ck_flip != 0 corrupts the checksum byte (checksum build only)
  task automatic frame(input string tag, input logic [7:0] p[NS],
                       input bit arm_hit, input logic [7:0] ck_flip);
    logic [W-1:0] e[$];
    logic [7:0]   x = '0;
    bit           ok = 1'b1;
    int           w;
    mon_clear();
    send(SOF, arm_hit ? 0 : $urandom_range(1, 3));
    for (int i = 0; i < NS; i++) begin
      send(p[i], $urandom_range(1, 4));
      x ^= p[i];
      e.push_back(W'(p[i] % (1 << W)));
    end
`ifdef BANNER_CHECKSUM_EN
    send(x ^ ck_flip, 1);
    ok = (ck_flip == 8'h00);
`endif
    wait_idle(100, w);
    if (ok) banner_exp = pack(p);
    check_syms(tag, e);
    chk({tag, "_start"}, n_start, 1);
    chk({tag, "_banner"}, banner_out, banner_exp);
    chk({tag, "_upd"}, n_upd, ok ? 1 : 0);
    chk({tag, "_ferr"}, n_ferr, ok ? 0 : 1);
    chk({tag, "_busy"}, busy, 0);
  endtask

  logic [7:0]   pl[NS];
  logic [W-1:0] ex[$];
  logic [7:0]   b;
  int           w;

  initial begin
    #12;
    chk("rst_start", s2p_start, 0);
    chk("rst_new", s2p_new_data, 0);
    chk("rst_banner", banner_out, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (2) @(posedge clk); #1;

    for (int i = 0; i < NS; i++) pl[i] = 8'(i + 1);
    frame("basic", pl, 0, 0);
    chk("basic_word", banner_out, 24'h123456);

    send(8'h41, 1);
    send(8'h13, 2);
    for (int i = 0; i < NS; i++) pl[i] = 8'(8'h0A + i);
    frame("junk", pl, 0, 0);
    chk("junk_word", banner_out, 24'hABCDEF);

    for (int r = 0; r < 4; r++) begin
      b = $urandom;
      if (b == SOF) b ^= 8'h01;
      send(b, 2);
      for (int i = 0; i < NS; i++) pl[i] = $urandom;
      pl[$urandom_range(0, NS - 1)] = SOF;
      frame($sformatf("rnd%0d", r), pl, r[0], 0);
    end

    mon_clear();
    send(SOF, 1);
    send(8'h01, 1);
    send(8'h02, 1);
    send(8'h03, 0);
    wait_idle(TO + 60, w);
    ex = '{4'h1, 4'h2, 4'h3, 4'h0, 4'h0, 4'h0};
    check_syms("tmo", ex);
    chk("tmo_ferr", n_ferr, 1);
    chk("tmo_upd", n_upd, 0);
    chk("tmo_banner", banner_out, banner_exp);
    chk("tmo_late", w >= TO, 1);
    chk("tmo_prompt", w <= TO + 20, 1);

    for (int i = 0; i < NS; i++) pl[i] = 8'(8'h07 + i);
    frame("armhit", pl, 1, 0);
    chk("armhit_word", banner_out, 24'h789ABC);

    mon_clear();
    send(SOF, 1);
    send(8'h05, 1);
    send(8'h06, 2);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_start", s2p_start, 0);
    chk("mid_rst_new", s2p_new_data, 0);
    chk("mid_rst_data", s2p_data, 0);
    chk("mid_rst_banner", banner_out, 0);
    chk("mid_rst_upd", banner_update, 0);
    chk("mid_rst_ferr", frame_err, 0);
    chk("mid_rst_busy", busy, 0);
    banner_exp = '0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < NS; i++) pl[i] = $urandom;
    frame("post_rst", pl, 0, 0);

`ifdef BANNER_CHECKSUM_EN
    for (int i = 0; i < NS; i++) pl[i] = 8'(i + 1);
    frame("ck_bad", pl, 0, 8'h07);
    frame("ck_good", pl, 0, 0);
    chk("ck_good_word", banner_out, 24'h123456);
`endif

    chk("no_overlap", n_overlap, 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got 1 exp 0");
    $fatal(1, "global timeout");
  end

endmodule
